ntt_loop_ctrl: RTL and testbench

Loop sequencer for the unified Kyber/Dilithium NTT datapath. On a start pulse it walks every stage of the selected transform and emits one (stage, k, j, i) iteration tuple per cycle to the address generator, which expands each tuple into four coefficient addresses. It inserts a programmable drain gap between stages, honours a downstream stall, and reports busy and done to the top-level controller.

---
 rtl/ntt_pkg.sv | 33 +++
 rtl/ntt_stage_bounds.sv | 19 +
 rtl/ntt_loop_ctrl.sv | 138 +++++++++++++
 tb/tb_ntt_loop_ctrl.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/ntt_pkg.sv
// Shared constants, FSM encodings and per-stage loop bounds for the Kyber/Dilithium NTT sequencer.
package ntt_pkg;

  localparam logic KD_KYBER     = 1'b0;
  localparam logic KD_DILITHIUM = 1'b1;

  localparam int NUM_STAGES_KYBER = 4;
  localparam int NUM_STAGES_DIL   = 8;

  localparam logic [2:0] KYBER_LAST_STAGE = 3'(NUM_STAGES_KYBER - 1);
  localparam logic [2:0] DIL_LAST_STAGE   = 3'(NUM_STAGES_DIL - 1);
  localparam logic [4:0] I_MAX            = 5'd31;

  typedef logic [1:0] state_t;
  localparam state_t ST_IDLE = 2'd0;
  localparam state_t ST_RUN  = 2'd1;
  localparam state_t ST_GAP  = 2'd2;
  localparam state_t ST_DONE = 2'd3;

  // Bounds are all-ones masks: 127 >> (7-s) == 2^s - 1, and 4^s - 1 uses a shift of 2s.
  function automatic logic [6:0] j_bound(input logic kd, input logic [2:0] s);
    if (kd == KD_DILITHIUM) return 7'h7f >> (3'd7 - s);
    if (s == KYBER_LAST_STAGE) return 7'd0;
    return 7'h7f >> (3'd7 - {s[1:0], 1'b0});
  endfunction

  function automatic logic [6:0] k_bound(input logic kd, input logic [2:0] s);
    if (kd == KD_DILITHIUM) return 7'h7f >> s;
    if (s == KYBER_LAST_STAGE) return 7'd0;
    return 7'h1f >> {s[1:0], 1'b0};
  endfunction

endpackage

// File: rtl/ntt_stage_bounds.sv
// Combinational per-stage loop bounds, shared with the twiddle-address logic.
module ntt_stage_bounds
  import ntt_pkg::*;
(
  input  logic       kd_mode,
  input  logic [2:0] stage,
  output logic [6:0] j_max,
  output logic [6:0] k_max,
  output logic       use_i,
  output logic       last_stage
);

  assign j_max      = j_bound(kd_mode, stage);
  assign k_max      = k_bound(kd_mode, stage);
  assign use_i      = (kd_mode == KD_KYBER) && (stage == KYBER_LAST_STAGE);
  assign last_stage = (kd_mode == KD_DILITHIUM) ? (stage == DIL_LAST_STAGE)
                                                : (stage == KYBER_LAST_STAGE);

endmodule

// File: rtl/ntt_loop_ctrl.sv
// NTT loop sequencer: emits one (stage, k, j, i) tuple per cycle with drain gaps between stages.
module ntt_loop_ctrl
  import ntt_pkg::*;
#(
  parameter int STAGE_GAP = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       kd_mode,
  input  logic       stall,
  output logic [2:0] stage,
  output logic [6:0] k,
  output logic [6:0] j,
  output logic [4:0] i,
  output logic       kd_mode_o,
  output logic       valid,
  output logic       last_in_stage,
  output logic       busy,
  output logic       done
);

  localparam logic [3:0] GAP_LAST = 4'(STAGE_GAP - 1);

  state_t     state_q, state_d;
  logic [2:0] stage_q, stage_d;
  logic [6:0] k_q, k_d, j_q, j_d;
  logic [4:0] i_q, i_d;
  logic       mode_q, mode_d;
  logic [3:0] gap_q, gap_d;

  logic [6:0] j_max, k_max;
  logic       use_i, last_stage, stage_end;

  ntt_stage_bounds u_bounds (
    .kd_mode    (mode_q),
    .stage      (stage_q),
    .j_max      (j_max),
    .k_max      (k_max),
    .use_i      (use_i),
    .last_stage (last_stage)
  );

  assign stage_end = use_i ? (i_q == I_MAX) : ((j_q == j_max) && (k_q == k_max));

  always_comb begin
    // NOTE: every _d gets a hold default first so no path through the case infers a latch.
    state_d = state_q;
    stage_d = stage_q;
    k_d     = k_q;
    j_d     = j_q;
    i_d     = i_q;
    mode_d  = mode_q;
    gap_d   = gap_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_RUN;
          mode_d  = kd_mode;
          stage_d = 3'd0;
          k_d     = 7'd0;
          j_d     = 7'd0;
          i_d     = 5'd0;
        end
      end
      ST_RUN: begin
        if (!stall) begin
          if (stage_end) begin
            k_d = 7'd0;
            j_d = 7'd0;
            i_d = 5'd0;
            if (last_stage) begin
              state_d = ST_DONE;
              stage_d = 3'd0;
            end else begin
              stage_d = stage_q + 3'd1;
              if (STAGE_GAP != 0) begin
                state_d = ST_GAP;
                gap_d   = 4'd0;
              end
            end
          end else if (use_i) begin
            i_d = i_q + 5'd1;
          end else if (j_q != j_max) begin
            j_d = j_q + 7'd1;
          end else begin
            j_d = 7'd0;
            k_d = k_q + 7'd1;
          end
        end
      end
      ST_GAP: begin
        // Counters already hold the next stage's first tuple; only the gap count moves.
        if (!stall) begin
          if (gap_q == GAP_LAST) state_d = ST_RUN;
          else                   gap_d   = gap_q + 4'd1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        mode_d  = 1'b0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      stage_q <= 3'd0;
      k_q     <= 7'd0;
      j_q     <= 7'd0;
      i_q     <= 5'd0;
      mode_q  <= 1'b0;
      gap_q   <= 4'd0;
    end else begin
      state_q <= state_d;
      stage_q <= stage_d;
      k_q     <= k_d;
      j_q     <= j_d;
      i_q     <= i_d;
      mode_q  <= mode_d;
      gap_q   <= gap_d;
    end
  end

  assign stage         = stage_q;
  assign k             = k_q;
  assign j             = j_q;
  assign i             = i_q;
  assign kd_mode_o     = mode_q;
  assign valid         = (state_q == ST_RUN);
  assign last_in_stage = valid && stage_end;
  assign busy          = (state_q == ST_RUN) || (state_q == ST_GAP);
  assign done          = (state_q == ST_DONE);

endmodule

// File: tb/tb_ntt_loop_ctrl.sv
// Self-checking bench for ntt_loop_ctrl: a gap-0 and a gap-4 instance share one stimulus.
module tb_ntt_loop_ctrl;

  logic clk = 1'b0;
  logic rst, start, kd_mode, stall;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       valid;
    logic       last;
    logic       busy;
    logic       done;
    logic       kd;
    logic [2:0] stage;
    logic [6:0] k;
    logic [6:0] j;
    logic [4:0] i;
  } obs_t;

  typedef struct {
    logic kd;
    int   idx;
    obs_t exp;
  } vec_t;

  logic [2:0] stage0, stage4;
  logic [6:0] k0, k4, j0, j4;
  logic [4:0] i0, i4;
  logic kdo0, kdo4, valid0, valid4, last0, last4, busy0, busy4, done0, done4;

  ntt_loop_ctrl #(.STAGE_GAP(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .kd_mode(kd_mode), .stall(stall),
    .stage(stage0), .k(k0), .j(j0), .i(i0), .kd_mode_o(kdo0), .valid(valid0),
    .last_in_stage(last0), .busy(busy0), .done(done0)
  );

  ntt_loop_ctrl #(.STAGE_GAP(4)) dut4 (
    .clk(clk), .rst(rst), .start(start), .kd_mode(kd_mode), .stall(stall),
    .stage(stage4), .k(k4), .j(j4), .i(i4), .kd_mode_o(kdo4), .valid(valid4),
    .last_in_stage(last4), .busy(busy4), .done(done4)
  );

  obs_t obs0, obs4;
  assign obs0 = {valid0, last0, busy0, done0, kdo0, stage0, k0, j0, i0};
  assign obs4 = {valid4, last4, busy4, done4, kdo4, stage4, k4, j4, i4};

  int   n_checks = 0;
  int   n_errors = 0;
  int   sel = 0;
  int   n_last, n_gap;
  obs_t exp_q[$];
  obs_t beats[$];
  vec_t vecs[17];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic obs_t cur();
    return (sel == 4) ? obs4 : obs0;
  endfunction

  function automatic obs_t mk(logic v, logic l, logic kd, int s, int kk, int jj, int ii);
    obs_t o;
    o.valid = v;
    o.last  = l;
    o.busy  = 1'b1;
    o.done  = 1'b0;
    o.kd    = kd;
    o.stage = 3'(s);
    o.k     = 7'(kk);
    o.j     = 7'(jj);
    o.i     = 5'(ii);
    return o;
  endfunction

  // Expected cycle-by-cycle stream, written as the nested loops of the transform.
  task automatic build(input logic kd, input int gap);
    int ns;
    ns = kd ? 8 : 4;
    exp_q.delete();
    for (int s = 0; s < ns; s++) begin
      if (!kd && s == 3) begin
        for (int ii = 0; ii < 32; ii++) exp_q.push_back(mk(1, ii == 31, kd, s, 0, 0, ii));
      end else begin
        int jn, kn;
        jn = kd ? (1 << s) : (1 << (2 * s));
        kn = kd ? (128 >> s) : (32 >> (2 * s));
        for (int kk = 0; kk < kn; kk++)
          for (int jj = 0; jj < jn; jj++)
            exp_q.push_back(mk(1, (kk == kn - 1) && (jj == jn - 1), kd, s, kk, jj, 0));
      end
      if (s < ns - 1)
        for (int g = 0; g < gap; g++) exp_q.push_back(mk(0, 0, kd, s + 1, 0, 0, 0));
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (!(!busy0 && !busy4 && !done0 && !done4) && n < 3000) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_wait_bound", 32'(n < 3000), 32'd1);
    @(posedge clk); #1;
  endtask

  task automatic run(input logic kd, input int which, input int stall_idx, input int stall_len,
                     input int poke_idx, input logic poke_done, input int abort_idx);
    obs_t o;
    build(kd, which);
    sel = which;
    beats.delete();
    n_last = 0;
    n_gap  = 0;
    kd_mode = kd;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    for (int e = 0; e < exp_q.size(); e++) begin
      o = cur();
      check($sformatf("m%0d_kd%0d_e%0d", which, kd, e), 32'(o), 32'(exp_q[e]));
      if (o.valid) begin
        beats.push_back(o);
        if (o.last) n_last++;
      end else if (o.busy) n_gap++;
      if (e == abort_idx) begin
        #1 rst = 1'b1;
        #1 check("async_reset", 32'(cur()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        return;
      end
      if (e == stall_idx) begin
        stall = 1'b1;
        for (int r = 0; r < stall_len; r++) begin
          @(posedge clk); #1;
          if (r == stall_len - 1) stall = 1'b0;
          o = cur();
          if (!o.valid && o.busy) n_gap++;
          check($sformatf("stall_e%0d_r%0d", e, r), 32'(o), 32'(exp_q[e]));
        end
      end
      if (e == poke_idx) begin
        start   = 1'b1;
        kd_mode = ~kd;
      end
      @(posedge clk); #1;
      start   = 1'b0;
      kd_mode = kd;
    end
    o = cur();
    check("done_pulse", 32'({o.done, o.busy, o.valid, o.last}), 32'(4'b1000));
    if (poke_done) start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check("idle_after_done", 32'(cur()), 32'd0);
    @(posedge clk); #1;
    check("no_restart", 32'(cur()), 32'd0);
    wait_idle();
  endtask

  task automatic apply_table(input logic kd);
    for (int v = 0; v < 17; v++) begin
      if (vecs[v].kd == kd)
        check($sformatf("vec_kd%0d_beat%0d", kd, vecs[v].idx),
              (vecs[v].idx < beats.size()) ? 32'(beats[vecs[v].idx]) : 32'hdeadbeef,
              32'(vecs[v].exp));
    end
  endtask

  initial begin
    vecs[0]  = '{0, 0,    mk(1, 0, 0, 0, 0,  0,  0)};
    vecs[1]  = '{0, 31,   mk(1, 1, 0, 0, 31, 0,  0)};
    vecs[2]  = '{0, 32,   mk(1, 0, 0, 1, 0,  0,  0)};
    vecs[3]  = '{0, 35,   mk(1, 0, 0, 1, 0,  3,  0)};
    vecs[4]  = '{0, 36,   mk(1, 0, 0, 1, 1,  0,  0)};
    vecs[5]  = '{0, 40,   mk(1, 0, 0, 1, 2,  0,  0)};
    vecs[6]  = '{0, 63,   mk(1, 1, 0, 1, 7,  3,  0)};
    vecs[7]  = '{0, 79,   mk(1, 0, 0, 2, 0,  15, 0)};
    vecs[8]  = '{0, 96,   mk(1, 0, 0, 3, 0,  0,  0)};
    vecs[9]  = '{0, 127,  mk(1, 1, 0, 3, 0,  0,  31)};
    vecs[10] = '{1, 127,  mk(1, 1, 1, 0, 127, 0, 0)};
    vecs[11] = '{1, 768,  mk(1, 0, 1, 6, 0,  0,  0)};
    vecs[12] = '{1, 831,  mk(1, 0, 1, 6, 0,  63, 0)};
    vecs[13] = '{1, 832,  mk(1, 0, 1, 6, 1,  0,  0)};
    vecs[14] = '{1, 895,  mk(1, 1, 1, 6, 1,  63, 0)};
    vecs[15] = '{1, 896,  mk(1, 0, 1, 7, 0,  0,  0)};
    vecs[16] = '{1, 1023, mk(1, 1, 1, 7, 0,  127, 0)};

    rst = 1'b1; start = 1'b0; kd_mode = 1'b0; stall = 1'b0;
    #1;
    check("reset_dut0", 32'(obs0), 32'd0);
    check("reset_dut4", 32'(obs4), 32'd0);
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    check("idle_dut0", 32'(obs0), 32'd0);

    // Kyber, no gap; start re-pulsed (with flipped mode) at beat 10 and in the DONE cycle.
    run(1'b0, 0, -1, 0, 10, 1'b1, -1);
    check("kyber_beats", 32'(beats.size()), 32'd128);
    check("kyber_last_cnt", 32'(n_last), 32'd4);
    apply_table(1'b0);

    // Dilithium with a 4-cycle gap.
    run(1'b1, 4, -1, 0, -1, 1'b0, -1);
    check("dil_beats", 32'(beats.size()), 32'd1024);
    check("dil_last_cnt", 32'(n_last), 32'd8);
    check("dil_gap_cycles", 32'(n_gap), 32'd28);
    apply_table(1'b1);

    // Stall on Kyber beat 40 for 3 cycles.
    run(1'b0, 0, 40, 3, -1, 1'b0, -1);
    check("stall_beats", 32'(beats.size()), 32'd128);

    // Stall inside the first gap (entry 33) for 5 cycles.
    run(1'b0, 4, 33, 5, -1, 1'b0, -1);
    check("gap_stall_cycles", 32'(n_gap), 32'd17);

    // Reset during Dilithium stage 3, then a clean Kyber run.
    run(1'b1, 4, -1, 0, -1, 1'b0, 400);
    check("abort_dut0", 32'(obs0), 32'd0);
    @(posedge clk); #1;
    run(1'b0, 4, -1, 0, -1, 1'b0, -1);
    check("post_reset_beats", 32'(beats.size()), 32'd128);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
